// File: rtl/bus_arbiter4_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bus_arbiter4_pkg
// Description : Shared types and constants for the 4-requester bus arbiter.
// Revision    : 1.0  initial release
// ============================================================================
package bus_arbiter4_pkg;

  // Arbiter FSM encoding: one bit, two states.
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_t;

  // Default maximum grant hold time in cycles (legal 2..256).
  localparam int unsigned c_DEFAULT_TIMEOUT = 16;

  // Number of requesters and width of a requester index.
  localparam int unsigned c_NREQ  = 4;
  localparam int unsigned c_IDX_W = 2;

  // Binary requester index to one-hot grant vector.
  function automatic logic [c_NREQ-1:0] onehot4(input logic [c_IDX_W-1:0] idx);
    return {{(c_NREQ-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bus_arbiter4_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick4
// Description : Combinational round-robin pick: first set request bit found
//               scanning upward from ptr, wrapping 3 -> 0.
// Revision    : 1.0  initial release
// ============================================================================
module rr_pick4
  import bus_arbiter4_pkg::*;
(
  input  logic [c_NREQ-1:0]  req,
  input  logic [c_IDX_W-1:0] ptr,
  output logic               valid,
  output logic [c_IDX_W-1:0] idx
);

  logic [c_IDX_W-1:0] w_cand;

  // Walk offsets from farthest to nearest so the nearest set bit wins last.
  always_comb begin
    valid  = 1'b0;
    idx    = ptr;
    w_cand = '0;
    for (int k = c_NREQ - 1; k >= 0; k--) begin
      w_cand = ptr + c_IDX_W'(k);
      if (req[w_cand]) begin
        valid = 1'b1;
        idx   = w_cand;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/bus_arbiter4.sv
`default_nettype none
// ============================================================================
// Module      : bus_arbiter4
// Description : 4-requester round-robin bus arbiter with hold timeout.
//               Registered one-hot grant and binary select; a grant ends on
//               ack, requester withdrawal, or after TIMEOUT cycles.
// Revision    : 1.0  initial release
// ============================================================================
module bus_arbiter4
  import bus_arbiter4_pkg::*;
#(
  parameter int unsigned TIMEOUT = c_DEFAULT_TIMEOUT  // legal range 2..256
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [c_NREQ-1:0]  req,
  input  logic               ack,
  output logic [c_NREQ-1:0]  gnt,
  output logic [c_IDX_W-1:0] sel,
  output logic               busy,
  output logic               timeout
);

  // Counter only has to reach TIMEOUT-1, so ceil(log2(TIMEOUT)) bits suffice.
  localparam int unsigned        c_CNT_W    = $clog2(TIMEOUT);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);

  arb_state_t         r_state;
  logic [c_NREQ-1:0]  r_gnt;
  logic [c_IDX_W-1:0] r_sel;
  logic [c_IDX_W-1:0] r_ptr;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_timeout;

  arb_state_t         w_state_nxt;
  logic [c_NREQ-1:0]  w_gnt_nxt;
  logic [c_IDX_W-1:0] w_sel_nxt;
  logic [c_IDX_W-1:0] w_ptr_nxt;
  logic [c_CNT_W-1:0] w_cnt_nxt;
  logic               w_timeout_nxt;

  logic               w_pick_valid;
  logic [c_IDX_W-1:0] w_pick_idx;

  rr_pick4 u_pick (
    .req   (req),
    .ptr   (r_ptr),
    .valid (w_pick_valid),
    .idx   (w_pick_idx)
  );

  // State and output registers; reset clears everything, even mid-grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_gnt     <= '0;
      r_sel     <= '0;
      r_ptr     <= '0;
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_gnt     <= w_gnt_nxt;
      r_sel     <= w_sel_nxt;
      r_ptr     <= w_ptr_nxt;
      r_cnt     <= w_cnt_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  // Next-state logic: ack beats withdrawal beats timeout when ending a grant.
  always_comb begin
    w_state_nxt   = r_state;
    w_gnt_nxt     = r_gnt;
    w_sel_nxt     = r_sel;
    w_ptr_nxt     = r_ptr;
    w_cnt_nxt     = r_cnt;
    w_timeout_nxt = 1'b0;

    case (r_state)
      ST_IDLE: begin
        // ack is ignored here; only a pending request moves us on.
        if (w_pick_valid) begin
          w_state_nxt = ST_BUSY;
          w_gnt_nxt   = onehot4(w_pick_idx);
          w_sel_nxt   = w_pick_idx;
          w_cnt_nxt   = '0;
        end
      end
      ST_BUSY: begin
        // r_sel is the current winner; sel itself is left unchanged on release.
        if (ack || !req[r_sel] || (r_cnt == c_CNT_LAST)) begin
          w_state_nxt   = ST_IDLE;
          w_gnt_nxt     = '0;
          w_ptr_nxt     = r_sel + 1'b1;
          w_cnt_nxt     = '0;
          w_timeout_nxt = !ack && req[r_sel];
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_gnt_nxt   = '0;
      end
    endcase
  end

  assign gnt     = r_gnt;
  assign sel     = r_sel;
  assign busy    = |r_gnt;
  assign timeout = r_timeout;

endmodule
`default_nettype wire
